// File: rtl/alu_issue_pkg.sv
// Shared constants and the decoded-entry record for the ALU issue stage.
package alu_issue_pkg;

    localparam int unsigned DATA_W = 32;

    // Major opcodes handled by the issue stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 encodings accepted on OP / shift-immediate forms
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // func3 operation selects as understood by the ALU
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef struct packed {
        logic [DATA_W-1:0] data_in1;
        logic [DATA_W-1:0] data_in2;
        logic [2:0]        func3;
        logic              func;
        logic              sub_en;
        logic [4:0]        rd;
        logic              rd_wen;
        logic              illegal;
    } issue_entry_t;

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational OP / OP-IMM decoder producing one issue entry.
// ALU_ISSUE_LUI_EN: also decode LUI and AUIPC (otherwise they are illegal).
module alu_issue_dec
    import alu_issue_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output issue_entry_t    entry
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

`ifndef ALU_ISSUE_LUI_EN
    logic unused_bits;
    assign unused_bits = ^{pc, inst[19:15]};
`endif

    // Decode the instruction; illegal encodings collapse to a zeroed entry
    always_comb begin
        issue_entry_t e;
        logic         ill;
        e   = '0;
        ill = 1'b0;
        unique case (opcode)
            OPC_OP_IMM: begin
                e.data_in1 = rs1_data;
                e.data_in2 = {{20{inst[31]}}, inst[31:20]};
                e.func3    = f3;
                if (f3 == F3_SLL) begin
                    e.data_in2 = {27'b0, inst[24:20]};
                    ill        = (f7 != F7_BASE);
                end else if (f3 == F3_SR) begin
                    e.data_in2 = {27'b0, inst[24:20]};
                    e.func     = inst[30];
                    ill        = (f7 != F7_BASE) && (f7 != F7_ALT);
                end
            end
            OPC_OP: begin
                e.data_in1 = rs1_data;
                e.data_in2 = rs2_data;
                e.func3    = f3;
                e.func     = (f3 == F3_SR) && inst[30];
                e.sub_en   = (f3 == F3_ADD) && inst[30];
                ill        = !((f7 == F7_BASE) ||
                               ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))));
            end
`ifdef ALU_ISSUE_LUI_EN
            OPC_LUI: begin
                e.data_in2 = {inst[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                e.data_in1 = pc;
                e.data_in2 = {inst[31:12], 12'b0};
            end
`endif
            default: ill = 1'b1;
        endcase
        if (ill) begin
            e = '0;
        end
        e.rd      = inst[11:7];
        e.illegal = ill;
        e.rd_wen  = !ill && (inst[11:7] != 5'd0);
        entry     = e;
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decoder followed by a two-entry skid buffer.
// ALU_ISSUE_LUI_EN: enables LUI/AUIPC decode in alu_issue_dec.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] data_in1,
    output logic [XLEN-1:0] data_in2,
    output logic [2:0]      func3,
    output logic            func,
    output logic            sub_en,
    output logic [4:0]      rd,
    output logic            rd_wen,
    output logic            illegal
);

    issue_entry_t dec_entry;
    issue_entry_t main_q;
    issue_entry_t skid_q;
    logic         main_v;
    logic         skid_v;
    logic         accept;
    logic         consume;

    alu_issue_dec #(.XLEN(XLEN)) u_dec (
        .inst     (inst),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .entry    (dec_entry)
    );

    // in_ready is a pure function of a flop, so it is effectively registered
    assign in_ready = !skid_v;
    assign accept   = in_valid && in_ready;
    assign consume  = main_v && out_ready;

    // Skid buffer: main drives the outputs, skid absorbs one stalled accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (consume) begin
            // accept and skid_v are mutually exclusive, so skid always wins here
            if (skid_v) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end else if (accept) begin
                main_q <= dec_entry;
            end else begin
                main_v <= 1'b0;
            end
        end else if (!main_v) begin
            if (accept) begin
                main_q <= dec_entry;
                main_v <= 1'b1;
            end
        end else if (accept) begin
            skid_q <= dec_entry;
            skid_v <= 1'b1;
        end
    end

    assign out_valid = main_v;
    assign data_in1  = main_q.data_in1;
    assign data_in2  = main_q.data_in2;
    assign func3     = main_q.func3;
    assign func      = main_q.func;
    assign sub_en    = main_q.sub_en;
    assign rd        = main_q.rd;
    assign rd_wen    = main_q.rd_wen;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_in1;
    logic [31:0] data_in2;
    logic [2:0]  func3;
    logic        func;
    logic        sub_en;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    alu_issue #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .func3     (func3),
        .func      (func),
        .sub_en    (sub_en),
        .rd        (rd),
        .rd_wen    (rd_wen),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  f3;
        logic        fn;
        logic        sub;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_now();
        return {20'b0, func3, func, sub_en, rd, rd_wen, illegal};
    endfunction

    function automatic logic [31:0] ctrl_of(input vec_t v);
        return {20'b0, v.f3, v.fn, v.sub, v.rd, v.wen, v.ill};
    endfunction

    // Drive one ADDI xN,x0,imm style entry tagged by rs1_data
    task automatic drive_tag(input logic [31:0] tag);
        inst     = 32'h00100093;
        pc       = 32'h0;
        rs1_data = tag;
        rs2_data = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        //            inst          pc            rs1           rs2           d1            d2            f3    fn    sub   rd     wen   ill
        vecs[0]  = '{32'hFFF08293, 32'h0,        32'h5,        32'h0,        32'h5,        32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0};
        vecs[1]  = '{32'h402081B3, 32'h0,        32'hA,        32'h3,        32'hA,        32'h3,        3'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0};
        vecs[2]  = '{32'h4030D093, 32'h0,        32'h80,       32'h9,        32'h80,       32'h3,        3'd5, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0};
        vecs[3]  = '{32'h023100B3, 32'h0,        32'h11,       32'h22,       32'h0,        32'h0,        3'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1};
        vecs[4]  = '{32'h00000013, 32'h0,        32'h77,       32'h0,        32'h77,       32'h0,        3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
`ifdef ALU_ISSUE_LUI_EN
        vecs[5]  = '{32'h12345097, 32'h80000000, 32'h1,       32'h2,        32'h80000000, 32'h12345000, 3'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0};
`else
        vecs[5]  = '{32'h12345097, 32'h80000000, 32'h1,       32'h2,        32'h0,        32'h0,        3'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1};
`endif
        vecs[6]  = '{32'h40419113, 32'h0,        32'h33,       32'h0,        32'h0,        32'h0,        3'd0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1};
        vecs[7]  = '{32'h01F1D113, 32'h0,        32'hF0F0F0F0, 32'h0,        32'hF0F0F0F0, 32'h1F,       3'd5, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0};
        vecs[8]  = '{32'h4000F213, 32'h0,        32'h1234,     32'h0,        32'h1234,     32'h400,      3'd7, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0};
        vecs[9]  = '{32'h8000B213, 32'h0,        32'h9,        32'h0,        32'h9,        32'hFFFFF800, 3'd3, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0};
        vecs[10] = '{32'h4020F1B3, 32'h0,        32'h5,        32'h6,        32'h0,        32'h0,        3'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1};
        vecs[11] = '{32'h4020D1B3, 32'h0,        32'hDEAD0000, 32'h4,        32'hDEAD0000, 32'h4,        3'd5, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0};
        vecs[12] = '{32'h0000A083, 32'h0,        32'h5,        32'h6,        32'h0,        32'h0,        3'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1};
        vecs[13] = '{32'h0230D093, 32'h0,        32'h5,        32'h6,        32'h0,        32'h0,        3'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        inst = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        #12;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset_d1",        data_in1,           32'd0);
        chk("reset_d2",        data_in2,           32'd0);
        chk("reset_ctrl",      ctrl_now(),         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: back-to-back accepts, one per cycle, each checked a cycle later
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            inst = vecs[i].inst; pc = vecs[i].pc;
            rs1_data = vecs[i].rs1; rs2_data = vecs[i].rs2;
            in_valid = 1'b1;
            chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d_d1", i), data_in1, vecs[i].d1);
            chk($sformatf("v%0d_d2", i), data_in2, vecs[i].d2);
            chk($sformatf("v%0d_ctrl", i), ctrl_now(), ctrl_of(vecs[i]));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain_out_valid", {31'b0, out_valid}, 32'd0);

        // Stall: three accepts with out_ready low, then release
        @(negedge clk);
        out_ready = 1'b0; drive_tag(32'hA); in_valid = 1'b1;
        @(posedge clk); #1;
        chk("stall_rdy_after1", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        drive_tag(32'hB);
        @(posedge clk); #1;
        chk("stall_rdy_after2", {31'b0, in_ready}, 32'd0);
        chk("stall_main_a", data_in1, 32'hA);
        @(negedge clk);
        drive_tag(32'hC);
        @(posedge clk); #1;
        chk("stall_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_hold_a", data_in1, 32'hA);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_b", data_in1, 32'hB);
        chk("release_rdy", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("release_c", data_in1, 32'hC);
        chk("release_c_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("release_empty", {31'b0, out_valid}, 32'd0);

        // Flush with two entries buffered and a simultaneous offer
        @(negedge clk);
        out_ready = 1'b0; drive_tag(32'h1); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_tag(32'h2);
        @(posedge clk);
        @(negedge clk);
        drive_tag(32'h3); flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready",  {31'b0, in_ready},  32'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("flush_no_emit", {31'b0, out_valid}, 32'd0);

        // Reset mid-stream is immediate, then first accept behaves as from empty
        @(negedge clk);
        out_ready = 1'b0; drive_tag(32'h55); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_tag(32'h66);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("midrst_d1",        data_in1,           32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; drive_tag(32'h77);
        @(posedge clk); #1;
        chk("postrst_valid", {31'b0, out_valid}, 32'd1);
        chk("postrst_d1",    data_in1,           32'h77);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("postrst_drain", {31'b0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
